// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
// Multi-cycle data-memory controller for the MEM stage. Owns a byte-addressed,
// little-endian RAM of 2**ADDR_WIDTH bytes. It performs byte-lane stores and
// sign/zero-extended loads behind a valid/ready handshake. Loads take LATENCY
// cycles. Misaligned or illegal-size requests skip the RAM and return an error
// response.
//
// Parameters:
//   WIDTH       data width, 32 or 64
//   ADDR_WIDTH  number of decoded byte-address bits
//   LATENCY     load latency in cycles (1..8)
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   req_valid/ready request handshake
//   req_we          1 = store, 0 = load
//   req_size        00 byte, 01 half, 10 word, 11 doubleword (WIDTH=64 only)
//   req_unsigned    zero-extend loads when 1
//   req_addr        byte address (upper bits ignored)
//   req_wdata       store data (low bytes used per size)
//   resp_valid      one-cycle response pulse
//   resp_rdata      extended load data, 0 for stores/errors
//   resp_err        misaligned or illegal-size access
//   busy            controller cannot take a new request
//
// Build option:
//   DATA_MEM_BACK2BACK_EN  when defined, a request may also be accepted in
//                          RESP, giving one response per cycle for stores.
module data_mem_ctrl #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             busy
);

    localparam int NBYTES = WIDTH / 8;
    localparam int DEPTH  = 1 << ADDR_WIDTH;

    // WAIT preload; unused when LATENCY=1 because loads go straight to RESP
    localparam logic [2:0] WAIT_INIT = 3'((LATENCY > 1) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           r_state, w_nextState;
    logic [2:0]       r_count, w_nextCount;
    logic [WIDTH-1:0] r_rdata, w_nextRdata;
    logic             r_err, w_nextErr;

    logic [7:0]            r_mem [0:DEPTH-1];
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [3:0]            w_numBytes;
    logic                  w_aligned;
    logic                  w_sizeLegal;
    logic                  w_err;
    logic                  w_accept;
    logic [WIDTH-1:0]      w_rawData;
    logic [WIDTH-1:0]      w_extData;
    logic                  w_signBit;
    logic [7:0]            w_fillByte;

    assign w_addr     = req_addr[ADDR_WIDTH-1:0];
    assign w_numBytes = 4'd1 << req_size;

    generate
        if (ADDR_WIDTH < WIDTH) begin : g_unusedAddr
            logic w_unused;
            assign w_unused = ^req_addr[WIDTH-1:ADDR_WIDTH];
        end
    endgenerate

    // Request classification: alignment per access size, and doubleword only
    // when the data path is wide enough to carry it.
    always_comb begin
        w_aligned = 1'b1;
        case (req_size)
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = (req_addr[0] == 1'b0);
            2'b10:   w_aligned = (req_addr[1:0] == 2'b00);
            default: w_aligned = (req_addr[2:0] == 3'b000);
        endcase
    end

    assign w_sizeLegal = (int'(w_numBytes) <= NBYTES);
    assign w_err       = !(w_aligned && w_sizeLegal);

`ifdef DATA_MEM_BACK2BACK_EN
    assign req_ready = (r_state == IDLE) || (r_state == RESP);
    assign busy      = (r_state == WAIT);
`else
    assign req_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
`endif

    assign w_accept = req_valid && req_ready;

    // Combinational view of the full-width word at the request address.
    // Aligned accesses never cross the top of RAM. The index is still kept
    // modulo the RAM size so every lane stays in range.
    always_comb begin
        w_rawData = '0;
        for (int i = 0; i < NBYTES; i++) begin
            w_rawData[i*8 +: 8] = r_mem[w_addr + ADDR_WIDTH'(i)];
        end
    end

    // Sign/zero extension. Lanes above the access size are filled with the
    // extension byte. Full-width loads have no fill lanes, so req_unsigned
    // has no effect on them.
    always_comb begin
        w_extData = '0;
        case (req_size)
            2'b00:   w_signBit = w_rawData[7];
            2'b01:   w_signBit = w_rawData[15];
            2'b10:   w_signBit = w_rawData[31];
            default: w_signBit = w_rawData[WIDTH-1];
        endcase
        w_fillByte = req_unsigned ? 8'h00 : {8{w_signBit}};
        for (int i = 0; i < NBYTES; i++) begin
            w_extData[i*8 +: 8] = (i < int'(w_numBytes)) ? w_rawData[i*8 +: 8] : w_fillByte;
        end
    end

    // Byte-lane store at the acceptance edge. RAM has no reset.
    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_err) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (i < int'(w_numBytes)) begin
                    r_mem[w_addr + ADDR_WIDTH'(i)] <= req_wdata[i*8 +: 8];
                end
            end
        end
    end

    // Next-state logic. An accepted request always starts from scratch,
    // whether it arrives in IDLE or (back-to-back build) in RESP. Load data is
    // captured at acceptance and held until the RESP cycle.
    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        w_nextRdata = r_rdata;
        w_nextErr   = r_err;

        case (r_state)
            IDLE: ;
            WAIT: begin
                if (r_count == 3'd0) begin
                    w_nextState = RESP;
                end else begin
                    w_nextCount = r_count - 3'd1;
                end
            end
            RESP: begin
                w_nextState = IDLE;
                w_nextRdata = '0;
                w_nextErr   = 1'b0;
            end
            default: w_nextState = IDLE;
        endcase

        if (w_accept) begin
            if (w_err) begin
                w_nextState = RESP;
                w_nextRdata = '0;
                w_nextErr   = 1'b1;
            end else if (req_we) begin
                w_nextState = RESP;
                w_nextRdata = '0;
                w_nextErr   = 1'b0;
            end else begin
                w_nextRdata = w_extData;
                w_nextErr   = 1'b0;
                w_nextCount = WAIT_INIT;
                w_nextState = (LATENCY == 1) ? RESP : WAIT;
            end
        end
    end

    // State register. Reset drops any pending response immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= 3'd0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
            r_rdata <= w_nextRdata;
            r_err   <= w_nextErr;
        end
    end

    assign resp_valid = (r_state == RESP);
    assign resp_rdata = resp_valid ? r_rdata : '0;
    assign resp_err   = resp_valid && r_err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl
// Self-checking bench for data_mem_ctrl (WIDTH=32, ADDR_WIDTH=16, LATENCY=2).
// A byte-level associative-array memory model predicts load data, error
// flags and response timing for directed and random requests.
module tb_data_mem_ctrl;

    localparam int WIDTH      = 32;
    localparam int ADDR_WIDTH = 16;
    localparam int LATENCY    = 2;
    localparam int NB         = WIDTH / 8;

`ifdef DATA_MEM_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_rdata;
    logic             resp_err;
    logic             busy;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [7:0] modelMem [int];

    always #5 clk = ~clk;

    data_mem_ctrl #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .LATENCY    (LATENCY)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .busy         (busy)
    );

    // Single comparison point: counts and reports every check
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic int addrIndex(input logic [WIDTH-1:0] a);
        return int'(a[ADDR_WIDTH-1:0]);
    endfunction

    function automatic bit modelErr(input logic [1:0] size, input logic [WIDTH-1:0] addr);
        int nb;
        nb = 1 << size;
        if (nb > NB) return 1'b1;
        return (addrIndex(addr) % nb) != 0;
    endfunction

    function automatic logic [63:0] modelLoad(input logic [1:0] size, input logic uns, input logic [WIDTH-1:0] addr);
        int nb;
        int base;
        logic [63:0] v;
        logic [63:0] mask;
        nb   = 1 << size;
        base = addrIndex(addr);
        v    = 64'd0;
        for (int i = 0; i < nb; i++) begin
            v = v | (64'(modelMem[base + i]) << (8 * i));
        end
        if (!uns && nb < NB && v[8*nb-1]) begin
            v = v | (~64'd0 << (8 * nb));
        end
        mask = (WIDTH == 64) ? ~64'd0 : ((64'd1 << WIDTH) - 64'd1);
        return v & mask;
    endfunction

    function automatic void modelStore(input logic [1:0] size, input logic [WIDTH-1:0] addr, input logic [WIDTH-1:0] wdata);
        int nb;
        int base;
        nb   = 1 << size;
        base = addrIndex(addr);
        for (int i = 0; i < nb; i++) begin
            modelMem[base + i] = wdata[8*i +: 8];
        end
    endfunction

    // One complete transaction: drive, accept, then check timing and response
    task automatic applyStimulus(input string tag, input logic we, input logic [1:0] size,
                                 input logic uns, input logic [WIDTH-1:0] addr,
                                 input logic [WIDTH-1:0] wdata);
        bit          expErr;
        logic [63:0] expData;
        int          expLat;
        int          lat;
        bit          seen;

        expErr  = modelErr(size, addr);
        expData = (expErr || we) ? 64'd0 : modelLoad(size, uns, addr);
        expLat  = (expErr || we) ? 1 : LATENCY;

        @(negedge clk);
        checkOutput({tag, "/ready"}, 64'(req_ready), 64'd1);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
        if (!expErr && we) modelStore(size, addr, wdata);

        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 12) begin
            @(negedge clk);
            lat++;
            if (resp_valid) begin
                seen = 1'b1;
            end else begin
                checkOutput({tag, "/waitBusy"}, 64'(busy), 64'd1);
                checkOutput({tag, "/waitData"}, 64'(resp_rdata), 64'd0);
            end
        end
        checkOutput({tag, "/latency"}, seen ? 64'(lat) : 64'd0, 64'(expLat));
        if (seen) begin
            checkOutput({tag, "/rdata"}, 64'(resp_rdata), expData);
            checkOutput({tag, "/err"}, 64'(resp_err), 64'(expErr));
            checkOutput({tag, "/respBusy"}, 64'(busy), B2B ? 64'd0 : 64'd1);
        end
        @(negedge clk);
        checkOutput({tag, "/pulseEnd"}, 64'(resp_valid), 64'd0);
        checkOutput({tag, "/dataClr"}, 64'(resp_rdata), 64'd0);
        checkOutput({tag, "/errClr"}, 64'(resp_err), 64'd0);
    endtask

    initial begin
        int pulses;
        logic [15:0] low;

        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset/ready", 64'(req_ready), 64'd1);
        checkOutput("reset/valid", 64'(resp_valid), 64'd0);
        checkOutput("reset/rdata", 64'(resp_rdata), 64'd0);
        checkOutput("reset/err", 64'(resp_err), 64'd0);
        checkOutput("reset/busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        // Give the two test regions known contents (bottom and top of RAM)
        for (int a = 0; a < 64; a += 4) begin
            applyStimulus("initLow", 1'b1, 2'b10, 1'b0, WIDTH'(a), $urandom);
            applyStimulus("initHigh", 1'b1, 2'b10, 1'b0, WIDTH'(32'hFFC0 + a), $urandom);
        end

        applyStimulus("stWord", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        applyStimulus("ldWord", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        checkOutput("ldWord/model", modelLoad(2'b10, 1'b0, 32'h10), 64'hDEADBEEF);

        applyStimulus("stByte", 1'b1, 2'b00, 1'b0, 32'h21, 32'hABCD1280);
        applyStimulus("ldByteS", 1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
        applyStimulus("ldByteU", 1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
        applyStimulus("ldByte20", 1'b0, 2'b00, 1'b1, 32'h20, 32'h0);
        applyStimulus("ldByte22", 1'b0, 2'b00, 1'b1, 32'h22, 32'h0);
        applyStimulus("ldByte23", 1'b0, 2'b00, 1'b1, 32'h23, 32'h0);
        checkOutput("ldByteS/model", modelLoad(2'b00, 1'b0, 32'h21), 64'hFFFFFF80);

        applyStimulus("misHalf", 1'b0, 2'b01, 1'b0, 32'h13, 32'h0);
        applyStimulus("misWord", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
        applyStimulus("misStore", 1'b1, 2'b10, 1'b0, 32'h12, 32'h55555555);
        applyStimulus("size11", 1'b0, 2'b11, 1'b0, 32'h8, 32'h0);
        applyStimulus("untouched", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        applyStimulus("wrapAddr", 1'b0, 2'b10, 1'b0, 32'h1234FFFC, 32'h0);

        // Reset while a load is waiting: response must be dropped
        @(negedge clk);
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h10;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("rstMid/inWait", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstMid/ready", 64'(req_ready), 64'd1);
        checkOutput("rstMid/busy", 64'(busy), 64'd0);
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            pulses += int'(resp_valid);
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            pulses += int'(resp_valid);
        end
        checkOutput("rstMid/noPulse", 64'(pulses), 64'd0);
        applyStimulus("rstMid/reload", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

        // req_valid held high: one acceptance per response
        @(negedge clk);
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h3C;
        req_wdata = 32'h11223344;
        req_valid = 1'b1;
        modelStore(2'b10, 32'h3C, 32'h11223344);
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            pulses += int'(resp_valid);
        end
        req_valid = 1'b0;
        checkOutput("heldValid/pulses", 64'(pulses), B2B ? 64'd8 : 64'd4);
        repeat (3) @(negedge clk);
        applyStimulus("heldValid/load", 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0);

        // Random mix of loads, stores and misaligned requests
        for (int n = 0; n < 200; n++) begin
            low = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 63))
                                             : 16'(32'hFFC0 + $urandom_range(0, 63));
            applyStimulus("rand", ($urandom_range(0, 9) < 4), 2'($urandom_range(0, 3)),
                          1'($urandom), {16'($urandom), low}, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
